// File: rtl/clock_pkg.sv
// Shared encodings, digit widths and time limits for the clock_mode_ctrl slice.
// BCD increment helpers carry digit-by-digit; no binary-to-BCD conversion anywhere.
package clock_pkg;

    localparam int DU_W       = 4;   // units digit (BCD)
    localparam int DT_W       = 3;   // minutes/seconds tens digit
    localparam int HT_W       = 2;   // hours tens digit
    localparam int MODE_W     = 2;

    localparam int LIM_HOURS  = 23;
    localparam int LIM_MINSEC = 59;

    localparam logic [DU_W-1:0] LIM_UNITS      = 4'd9;
    localparam logic [DT_W-1:0] LIM_TENS       = DT_W'(LIM_MINSEC / 10);
    localparam logic [HT_W-1:0] HOUR_TENS_MAX  = HT_W'(LIM_HOURS / 10);
    localparam logic [DU_W-1:0] HOUR_UNITS_MAX = DU_W'(LIM_HOURS % 10);

    typedef enum logic [MODE_W-1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DT_W-1:0] d2;
        logic [DU_W-1:0] d1;
    } bcd60_t;

    typedef struct packed {
        logic [HT_W-1:0] d2;
        logic [DU_W-1:0] d1;
    } bcd24_t;

    function automatic logic bcd60_max(bcd60_t v);
        return (v.d2 == LIM_TENS) && (v.d1 == LIM_UNITS);
    endfunction

    function automatic bcd60_t bcd60_inc(bcd60_t v);
        bcd60_t n = v;
        if (v.d1 != LIM_UNITS) begin
            n.d1 = v.d1 + 1'b1;
        end else begin
            n.d1 = '0;
            n.d2 = (v.d2 == LIM_TENS) ? '0 : v.d2 + 1'b1;
        end
        return n;
    endfunction

    function automatic bcd24_t bcd24_inc(bcd24_t v);
        bcd24_t n = v;
        if ((v.d2 == HOUR_TENS_MAX) && (v.d1 == HOUR_UNITS_MAX)) begin
            n = '0;
        end else if (v.d1 == LIM_UNITS) begin
            n.d1 = '0;
            n.d2 = v.d2 + 1'b1;
        end else begin
            n.d1 = v.d1 + 1'b1;
        end
        return n;
    endfunction

endpackage

// File: rtl/clock_mode_ctrl_if.sv
// Control/display bundle between the clock controller and its driver.
interface clock_mode_ctrl_if;
    import clock_pkg::*;

    logic              tick;
    logic              btn_mode;
    logic              btn_inc;
    logic [DU_W-1:0]   sec_d1;
    logic [DT_W-1:0]   sec_d2;
    logic [DU_W-1:0]   min_d1;
    logic [DT_W-1:0]   min_d2;
    logic [DU_W-1:0]   hour_d1;
    logic [HT_W-1:0]   hour_d2;
    logic [MODE_W-1:0] mode;
    logic              blink;
    logic              min_pulse;

    modport master (
        output tick, btn_mode, btn_inc,
        input  sec_d1, sec_d2, min_d1, min_d2, hour_d1, hour_d2, mode, blink, min_pulse
    );

    modport slave (
        input  tick, btn_mode, btn_inc,
        output sec_d1, sec_d2, min_d1, min_d2, hour_d1, hour_d2, mode, blink, min_pulse
    );

endinterface

// File: rtl/clock_btn_edge.sv
// Button synchronizer plus rising-edge detector producing a registered one-cycle event.
// Events stay disarmed after reset until a genuine low level has been sampled.
module clock_btn_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_evt
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   r_prev;
    logic                   r_armed;
    logic                   r_evt;
    logic                   w_sync;
    logic                   w_filled;

    assign w_sync   = r_sync[SYNC_STAGES-1];
    // Chain output only reflects a real sample once the reset zeros have flushed out.
    assign w_filled = r_fill[SYNC_STAGES-1];
    assign o_evt    = r_evt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync  <= '0;
            r_fill  <= '0;
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
            r_evt   <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_btn};
            r_fill  <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            r_prev  <= w_sync;
            r_armed <= r_armed | (w_filled & ~w_sync);
            r_evt   <= w_sync & ~r_prev & r_armed;
        end
    end

endmodule

// File: rtl/clock_mode_ctrl.sv
// HH:MM:SS BCD clock with RUN / SET_HOUR / SET_MIN editing driven by two raw buttons.
module clock_mode_ctrl
    import clock_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    clock_mode_ctrl_if.slave   bus
);

    logic   w_mode_evt;
    logic   w_inc_evt;
    state_t r_state;
    bcd60_t r_sec;
    bcd60_t r_min;
    bcd24_t r_hour;
    logic   r_blink;
    logic   r_min_pulse;

    clock_btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mode_edge (
        .clk(clk), .reset(reset), .i_btn(bus.btn_mode), .o_evt(w_mode_evt)
    );

    clock_btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_inc_edge (
        .clk(clk), .reset(reset), .i_btn(bus.btn_inc), .o_evt(w_inc_evt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_RUN;
            r_sec       <= '0;
            r_min       <= '0;
            r_hour      <= '0;
            r_blink     <= 1'b1;
            r_min_pulse <= 1'b0;
        end else begin
            r_min_pulse <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    r_blink <= 1'b1;
                    // Mode press beats a coincident tick; seconds restart from 00 anyway.
                    if (w_mode_evt) begin
                        r_state <= ST_SET_HOUR;
                        r_sec   <= '0;
                    end else if (bus.tick) begin
                        r_sec <= bcd60_inc(r_sec);
                        if (bcd60_max(r_sec)) begin
                            r_min_pulse <= 1'b1;
                            r_min       <= bcd60_inc(r_min);
                            if (bcd60_max(r_min)) r_hour <= bcd24_inc(r_hour);
                        end
                    end
                end
                ST_SET_HOUR: begin
                    if (w_mode_evt) begin
                        r_state <= ST_SET_MIN;
                        r_blink <= 1'b1;
                    end else if (w_inc_evt) begin
                        r_hour  <= bcd24_inc(r_hour);
                        r_blink <= 1'b1;
                    end else if (bus.tick) begin
                        r_blink <= ~r_blink;
                    end
                end
                ST_SET_MIN: begin
                    if (w_mode_evt) begin
                        r_state <= ST_RUN;
                        r_sec   <= '0;
                        r_blink <= 1'b1;
                    end else if (w_inc_evt) begin
                        r_min   <= bcd60_inc(r_min);
                        r_blink <= 1'b1;
                    end else if (bus.tick) begin
                        r_blink <= ~r_blink;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_blink <= 1'b1;
                end
            endcase
        end
    end

    assign bus.sec_d1    = r_sec.d1;
    assign bus.sec_d2    = r_sec.d2;
    assign bus.min_d1    = r_min.d1;
    assign bus.min_d2    = r_min.d2;
    assign bus.hour_d1   = r_hour.d1;
    assign bus.hour_d2   = r_hour.d2;
    assign bus.mode      = r_state;
    assign bus.blink     = r_blink;
    assign bus.min_pulse = r_min_pulse;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl: tick-count vector table plus button/reset sequences.
module tb_clock_mode_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   pulse_cnt = 0;
    int   pulse_at = -1;

    clock_mode_ctrl_if bus ();

    clock_mode_ctrl #(.SYNC_STAGES(2)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ticks;
        int exp_hms;
    } vec_t;

    function automatic int hms();
        return int'(bus.hour_d2) * 100000 + int'(bus.hour_d1) * 10000 +
               int'(bus.min_d2) * 1000 + int'(bus.min_d1) * 100 +
               int'(bus.sec_d2) * 10 + int'(bus.sec_d1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_tick(input int n);
        repeat (n) begin
            bus.tick = 1'b1;
            cyc();
            bus.tick = 1'b0;
            cyc();
        end
    endtask

    task automatic press_mode();
        bus.btn_mode = 1'b1; cyc(6);
        bus.btn_mode = 1'b0; cyc(6);
    endtask

    task automatic press_inc(input int n);
        repeat (n) begin
            bus.btn_inc = 1'b1; cyc(6);
            bus.btn_inc = 1'b0; cyc(6);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (bus.min_pulse === 1'b1) begin
            pulse_cnt++;
            pulse_at = hms();
        end
    end

    vec_t tv[6];

    initial begin
        tv[0] = '{1, 1};
        tv[1] = '{8, 9};
        tv[2] = '{1, 10};
        tv[3] = '{49, 59};
        tv[4] = '{1, 100};
        tv[5] = '{1, 101};

        bus.tick = 1'b0;
        bus.btn_mode = 1'b0;
        bus.btn_inc = 1'b0;
        cyc(3);
        chk("reset_time", hms(), 0);
        chk("reset_mode", int'(bus.mode), 0);
        chk("reset_blink", int'(bus.blink), 1);
        chk("reset_pulse", int'(bus.min_pulse), 0);
        reset = 1'b1;
        cyc(6);

        // Run from 00:00:00 through the first minute rollover
        pulse_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            do_tick(tv[i].ticks);
            chk($sformatf("run_vec%0d_time", i), hms(), tv[i].exp_hms);
            chk($sformatf("run_vec%0d_blink", i), int'(bus.blink), 1);
        end
        chk("run_pulse_count", pulse_cnt, 1);
        chk("run_pulse_at", pulse_at, 100);

        // Enter SET_HOUR: seconds cleared, 25 incs wrap hours to 01
        press_mode();
        chk("sethr_mode", int'(bus.mode), 1);
        chk("sethr_sec_clr", hms(), 100);
        press_inc(25);
        chk("sethr_25inc", hms(), 10100);
        chk("sethr_blink_inc", int'(bus.blink), 1);
        do_tick(1);
        chk("sethr_tick1_blink", int'(bus.blink), 0);
        chk("sethr_tick1_time", hms(), 10100);
        do_tick(1);
        chk("sethr_tick2_blink", int'(bus.blink), 1);
        chk("sethr_tick2_time", hms(), 10100);

        // Inc event coincident with tick: inc applied, blink forced high
        bus.btn_inc = 1'b1;
        cyc(3);
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        chk("tick_inc_time", hms(), 20100);
        chk("tick_inc_blink", int'(bus.blink), 1);
        cyc(5);
        bus.btn_inc = 1'b0;
        cyc(6);

        // Preload 23:59 then roll to midnight
        press_inc(21);
        chk("preload_hr", hms(), 230100);
        press_mode();
        chk("setmin_mode", int'(bus.mode), 2);
        press_inc(58);
        press_mode();
        chk("preload_run_mode", int'(bus.mode), 0);
        chk("preload_time", hms(), 235900);
        do_tick(58);
        chk("pre_wrap_time", hms(), 235958);
        pulse_cnt = 0;
        pulse_at = -1;
        do_tick(2);
        chk("midnight_time", hms(), 0);
        chk("midnight_pulse_count", pulse_cnt, 1);
        chk("midnight_pulse_at", pulse_at, 0);

        // SET_MIN minute wrap without carry into hours
        press_mode();
        press_inc(5);
        press_mode();
        press_inc(59);
        chk("setmin_59", hms(), 55900);
        press_inc(1);
        chk("setmin_wrap", hms(), 50000);
        press_mode();
        chk("resume_mode", int'(bus.mode), 0);
        do_tick(1);
        chk("resume_tick", hms(), 50001);

        // Both buttons rise together in RUN: mode wins
        bus.btn_mode = 1'b1;
        bus.btn_inc = 1'b1;
        cyc(6);
        bus.btn_mode = 1'b0;
        bus.btn_inc = 1'b0;
        cyc(6);
        chk("both_mode", int'(bus.mode), 1);
        chk("both_time", hms(), 50000);

        // Reset mid-edit with inc held through deassertion
        press_mode();
        press_inc(1);
        chk("edit_before_rst", hms(), 50100);
        bus.btn_inc = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(3);
        chk("rst_edit_time", hms(), 0);
        chk("rst_edit_mode", int'(bus.mode), 0);
        chk("rst_edit_blink", int'(bus.blink), 1);
        reset = 1'b1;
        cyc(8);
        press_mode();
        chk("held_mode", int'(bus.mode), 1);
        chk("held_no_inc", hms(), 0);
        bus.btn_inc = 1'b0;
        cyc(6);
        chk("release_no_inc", hms(), 0);
        press_inc(1);
        chk("repress_inc", hms(), 10000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
